// File: rtl/mmu_pkg.sv
// mmu_pkg: shared widths, address type and loader state encoding
package mmu_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int BAND_WIDTH = 25;
  localparam int SRAM_DEPTH = 1024;
  localparam int ROW_W = $clog2(SRAM_DEPTH);
  localparam int BANK_W = $clog2(BAND_WIDTH);
  localparam int SIZE_W = ROW_W + 1;
  typedef logic [BANK_W+ROW_W-1:0] addr_t;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;
endpackage

// File: rtl/bank_row_counter.sv
// bank_row_counter: beat-order bank/row walk with modulo-BAND_WIDTH bank wrap
module bank_row_counter
  import mmu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              inc,
  input  logic [SIZE_W-1:0] size,
  output logic [BANK_W-1:0] bank,
  output logic [ROW_W-1:0]  row,
  output logic              is_final
);
  logic bank_wrap;
  assign bank_wrap = bank == BANK_W'(BAND_WIDTH - 1);
  assign is_final = bank_wrap && {1'b0, row} == size - SIZE_W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bank <= '0;
      row  <= '0;
    end else if (clear) begin
      bank <= '0;
      row  <= '0;
    end else if (inc) begin
      bank <= bank_wrap ? '0 : bank + 1'b1;
      row  <= bank_wrap ? row + 1'b1 : row;
    end
endmodule

// File: rtl/input_buff_loader.sv
// input_buff_loader: scatters a byte stream across the input-buffer banks and flags burst completion
module input_buff_loader
  import mmu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [SIZE_W-1:0]     BURST_SIZE,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_last_i,
  output logic                  wea_o,
  output addr_t                 addra_o,
  output logic [DATA_WIDTH-1:0] dia_o,
  output logic                  busy_o,
  output logic                  load_done_o,
  output logic                  err_o
);
  state_t state;
  logic [SIZE_W-1:0] size_q;
  logic final_err;
  logic [BANK_W-1:0] bank;
  logic [ROW_W-1:0] row;
  logic is_final, accept, cfg_bad, clear;
  assign s_ready_o = state == LOAD;
  assign busy_o = state != IDLE;
  assign accept = s_valid_i && s_ready_o;
  assign cfg_bad = BURST_SIZE == '0 || BURST_SIZE > SIZE_W'(SRAM_DEPTH);
  assign clear = state == IDLE && start_i && !cfg_bad;
  bank_row_counter u_cnt (
    .clk(clk), .rst(rst), .clear(clear), .inc(accept), .size(size_q),
    .bank(bank), .row(row), .is_final(is_final)
  );
  // missing s_last_i on the final beat is reported alongside load_done_o
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      size_q      <= '0;
      final_err   <= 1'b0;
      wea_o       <= 1'b0;
      addra_o     <= '0;
      dia_o       <= '0;
      load_done_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      wea_o       <= accept;
      load_done_o <= 1'b0;
      err_o       <= 1'b0;
      if (accept) begin
        addra_o <= {bank, row};
        dia_o   <= s_data_i;
      end
      case (state)
        IDLE: if (start_i) begin
          err_o <= cfg_bad;
          if (!cfg_bad) begin
            size_q <= BURST_SIZE;
            state  <= LOAD;
          end
        end
        LOAD: if (accept) begin
          if (is_final) begin
            state     <= FLUSH;
            final_err <= !s_last_i;
          end else if (s_last_i) begin
            err_o <= 1'b1;
            state <= IDLE;
          end
        end
        FLUSH: begin
          load_done_o <= 1'b1;
          err_o       <= final_err;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_input_buff_loader.sv
// tb_input_buff_loader: randomized stream bench checked each cycle against a beat-index model
module tb_input_buff_loader;
  logic clk = 0, rst = 1, start_i = 0, s_valid_i = 0, s_last_i = 0;
  logic [10:0] burst_size = '0;
  logic [7:0] s_data_i = '0;
  logic s_ready_o, wea_o, busy_o, load_done_o, err_o;
  logic [14:0] addra_o;
  logic [7:0] dia_o;
  int pass_n = 0, total_n = 0, cyc = 0;
  int err_n = 0, done_n = 0, busy_n = 0, both_n = 0;
  int wea_cyc = 0, done_cyc = 0, err_cyc = 0;
  logic [14:0] wr_addr[$];
  logic [7:0] wr_data[$];
  int m_phase = 0, m_k = 0, m_n = 0;
  logic m_perr = 0, e_wea = 0, e_err = 0, e_done = 0;
  logic [14:0] e_addr = '0;
  logic [7:0] e_dia = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  input_buff_loader dut (
    .clk(clk), .rst(rst), .start_i(start_i), .BURST_SIZE(burst_size),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
    .wea_o(wea_o), .addra_o(addra_o), .dia_o(dia_o), .busy_o(busy_o),
    .load_done_o(load_done_o), .err_o(err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act !== exp) $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    else pass_n++;
  endtask

  // beat k lands in bank k%25, row k/25; completion/error timing from the handshake rules
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_phase <= 0; m_k <= 0; m_n <= 0; m_perr <= 0;
      e_wea <= 0; e_err <= 0; e_done <= 0; e_addr <= '0; e_dia <= '0;
    end else begin
      e_wea <= 0; e_err <= 0; e_done <= 0;
      case (m_phase)
        0: if (start_i) begin
          if (burst_size == 0 || burst_size > 1024) e_err <= 1;
          else begin m_phase <= 1; m_k <= 0; m_n <= int'(burst_size); end
        end
        1: if (s_valid_i) begin
          e_wea <= 1;
          e_addr <= 15'(((m_k % 25) * 1024) + (m_k / 25));
          e_dia <= s_data_i;
          m_k <= m_k + 1;
          if (m_k == m_n * 25 - 1) begin m_phase <= 2; m_perr <= !s_last_i; end
          else if (s_last_i) begin e_err <= 1; m_phase <= 0; end
        end
        2: begin e_done <= 1; e_err <= m_perr; m_phase <= 0; end
        default: m_phase <= 0;
      endcase
    end

  always @(negedge clk) begin
    chk("wea", 32'(wea_o), 32'(e_wea));
    chk("err", 32'(err_o), 32'(e_err));
    chk("done", 32'(load_done_o), 32'(e_done));
    chk("busy", 32'(busy_o), 32'(m_phase != 0));
    chk("ready", 32'(s_ready_o), 32'(m_phase == 1));
    chk("addr", 32'(addra_o), 32'(e_addr));
    chk("dia", 32'(dia_o), 32'(e_dia));
    if (wea_o) begin wr_addr.push_back(addra_o); wr_data.push_back(dia_o); wea_cyc = cyc; end
    if (err_o) begin err_n++; err_cyc = cyc; end
    if (load_done_o) begin done_n++; done_cyc = cyc; end
    if (busy_o) busy_n++;
    if (err_o && load_done_o) both_n++;
  end

  task automatic run_burst(input int n, input int beats, input int last_at, input bit rnd);
    int k = 0, c = 0;
    @(posedge clk); #1 start_i = 1; burst_size = 11'(n);
    @(posedge clk); #1 start_i = 0;
    while (k < beats && c < 2000) begin
      s_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data_i = 8'(k);
      s_last_i = (k == last_at);
      if (s_valid_i && s_ready_o) k++;
      c++;
      @(posedge clk); #1;
    end
    s_valid_i = 0; s_last_i = 0;
    chk("beats_accepted", 32'(k), 32'(beats));
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int n);
    @(posedge clk); #1 start_i = 1; burst_size = 11'(n);
    @(posedge clk); #1 start_i = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int b, e, d, bz;
    #1;
    chk("rst_wea", 32'(wea_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_addr", 32'(addra_o), 0);
    #12 rst = 0;
    // 1: 100 beats into 4 rows
    b = wr_addr.size(); e = err_n; d = done_n;
    run_burst(4, 100, 99, 0);
    chk("t1_writes", 32'(wr_addr.size() - b), 100);
    chk("t1_beat0", 32'(wr_addr[b]), 0);
    chk("t1_beat24", 32'(wr_addr[b + 24]), 24576);
    chk("t1_beat25", 32'(wr_addr[b + 25]), 1);
    chk("t1_beat99", 32'(wr_addr[b + 99]), 24579);
    chk("t1_dia99", 32'(wr_data[b + 99]), 99);
    chk("t1_err", 32'(err_n - e), 0);
    chk("t1_done", 32'(done_n - d), 1);
    chk("t1_done_lat", 32'(done_cyc - wea_cyc), 1);
    // 2: same burst with random valid gaps
    b = wr_addr.size(); e = err_n; d = done_n;
    run_burst(4, 100, 99, 1);
    chk("t2_writes", 32'(wr_addr.size() - b), 100);
    chk("t2_beat50", 32'(wr_addr[b + 50]), 2);
    chk("t2_dia50", 32'(wr_data[b + 50]), 50);
    chk("t2_done", 32'(done_n - d), 1);
    chk("t2_err", 32'(err_n - e), 0);
    // 3: bad sizes
    b = wr_addr.size(); e = err_n; bz = busy_n;
    cfg(0);
    cfg(1025);
    chk("t3_err", 32'(err_n - e), 2);
    chk("t3_busy", 32'(busy_n - bz), 0);
    chk("t3_writes", 32'(wr_addr.size() - b), 0);
    // 4: early last on beat 30
    b = wr_addr.size(); e = err_n; d = done_n;
    run_burst(2, 31, 30, 0);
    chk("t4_writes", 32'(wr_addr.size() - b), 31);
    chk("t4_addr", 32'(wr_addr[b + 30]), 5121);
    chk("t4_dia", 32'(wr_data[b + 30]), 30);
    chk("t4_err", 32'(err_n - e), 1);
    chk("t4_err_with_wea", 32'(err_cyc - wea_cyc), 0);
    chk("t4_done", 32'(done_n - d), 0);
    // 5: final beat without last
    b = wr_addr.size(); d = both_n;
    run_burst(1, 25, -1, 0);
    chk("t5_writes", 32'(wr_addr.size() - b), 25);
    chk("t5_err_and_done", 32'(both_n - d), 1);
    // 6: async reset at beat 40 with a write pending
    @(posedge clk); #1 start_i = 1; burst_size = 11'd4;
    @(posedge clk); #1 start_i = 0;
    for (int k = 0; k < 40; k++) begin
      s_valid_i = 1; s_data_i = 8'(k);
      @(posedge clk); #1;
    end
    s_valid_i = 0;
    chk("t6_pending_wea", 32'(wea_o), 1);
    #2 rst = 1;
    #1;
    chk("t6_rst_wea", 32'(wea_o), 0);
    chk("t6_rst_busy", 32'(busy_o), 0);
    chk("t6_rst_ready", 32'(s_ready_o), 0);
    chk("t6_rst_addr", 32'(addra_o), 0);
    chk("t6_rst_dia", 32'(dia_o), 0);
    #3 rst = 0;
    b = wr_addr.size(); d = done_n; e = err_n;
    run_burst(1, 25, 24, 0);
    chk("t6_restart_addr", 32'(wr_addr[b]), 0);
    chk("t6_restart_writes", 32'(wr_addr.size() - b), 25);
    chk("t6_done", 32'(done_n - d), 1);
    chk("t6_err", 32'(err_n - e), 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
